reg_window_file: RTL and testbench

REG_WINDOW_FILE -- requirements
Module: reg_window_file

---
 rtl/reg_window_file.sv | 159 +++++++++++++++
 tb/tb_reg_window_file.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_window_file.sv
// Windowed register file: NWIN on-chip windows in a circular buffer; overflowing calls spill
// the oldest window off-chip, and underflowing returns fill it back, one register per beat.
//
// state | meaning
// IDLE  | normal register access, window commands accepted
// SPILL | streaming oldest on-chip window out, one register per spillAck
// FILL  | loading window below cwp from fillData, one register per fillValid
module reg_window_file #(
    parameter int WIDTH     = 8,
    parameter int NWIN      = 4,
    parameter int LOCAL     = 4,
    parameter int MAX_SAVED = 15,
    localparam int AW = $clog2(LOCAL),
    localparam int SW = $clog2(MAX_SAVED + 1),
    localparam int CW = $clog2(NWIN),
    localparam int DW = $clog2(NWIN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             regWrite,
    input  logic [AW-1:0]    wrAddr,
    input  logic [AW-1:0]    rdAddr1,
    input  logic [AW-1:0]    rdAddr2,
    input  logic [WIDTH-1:0] wrData,
    output logic [WIDTH-1:0] rdData1,
    output logic [WIDTH-1:0] rdData2,
    input  logic             ldWnd,
    input  logic [1:0]       wndCtrl,
    output logic             stall,
    output logic [CW-1:0]    cwp,
    output logic [DW-1:0]    depth,
    output logic [SW-1:0]    saved,
    output logic             ovf,
    output logic             unf,
    output logic             spillReq,
    output logic [WIDTH-1:0] spillData,
    input  logic             spillAck,
    output logic             fillReq,
    input  logic [WIDTH-1:0] fillData,
    input  logic             fillValid
);

    typedef enum logic [1:0] {IDLE, SPILL, FILL} state_t;

    state_t           state, stateNext;
    logic [WIDTH-1:0] regs [NWIN][LOCAL];
    logic [AW-1:0]    beat;
    logic [CW-1:0]    cwpInc, cwpDec;
    logic             lastBeat;
    logic             doCall, doRet, doFlush, spillDone, fillDone, ovfNext, unfNext;

    assign cwpInc   = (cwp == CW'(NWIN - 1)) ? '0 : cwp + 1'b1;
    assign cwpDec   = (cwp == '0) ? CW'(NWIN - 1) : cwp - 1'b1;
    assign lastBeat = (beat == AW'(LOCAL - 1));

    assign rdData1  = regs[cwp][rdAddr1];
    assign rdData2  = regs[cwp][rdAddr2];
    assign stall    = (state != IDLE);
    assign spillReq = (state == SPILL);
    assign fillReq  = (state == FILL);
    // with the buffer full, the oldest window sits just past cwp
    assign spillData = (state == SPILL) ? regs[cwpInc][beat] : '0;

    always_comb begin
        stateNext = state;
        doCall    = 1'b0;
        doRet     = 1'b0;
        doFlush   = 1'b0;
        spillDone = 1'b0;
        fillDone  = 1'b0;
        ovfNext   = 1'b0;
        unfNext   = 1'b0;
        case (state)
            IDLE: begin
                if (ldWnd) begin
                    case (wndCtrl)
                        2'b01: begin
                            if (depth < DW'(NWIN))              doCall    = 1'b1;
                            else if (saved < SW'(MAX_SAVED))    stateNext = SPILL;
                            else                                ovfNext   = 1'b1;
                        end
                        2'b10: begin
                            if (depth > DW'(1))                 doRet     = 1'b1;
                            else if (saved != '0)               stateNext = FILL;
                            else                                unfNext   = 1'b1;
                        end
                        2'b11:   doFlush = 1'b1;
                        default: ;
                    endcase
                end
            end
            SPILL: begin
                if (spillAck && lastBeat) begin
                    spillDone = 1'b1;
                    stateNext = IDLE;
                end
            end
            FILL: begin
                if (fillValid && lastBeat) begin
                    fillDone  = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat  <= '0;
            cwp   <= '0;
            depth <= DW'(1);
            saved <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
            for (int w = 0; w < NWIN; w++)
                for (int r = 0; r < LOCAL; r++)
                    regs[w][r] <= '0;
        end else begin
            ovf <= ovfNext;
            unf <= unfNext;
            if (regWrite && state == IDLE)
                regs[cwp][wrAddr] <= wrData;
            if (state == IDLE)
                beat <= '0;
            else if ((state == SPILL && spillAck) || (state == FILL && fillValid))
                beat <= beat + 1'b1;
            if (state == FILL && fillValid)
                regs[cwpDec][beat] <= fillData;
            // a write in the same cycle targets cwp, never cwpInc, so clearing is safe
            if (doCall || spillDone) begin
                cwp <= cwpInc;
                for (int r = 0; r < LOCAL; r++)
                    regs[cwpInc][r] <= '0;
            end
            if (doCall)    depth <= depth + 1'b1;
            if (spillDone) saved <= saved + 1'b1;
            if (doRet) begin
                cwp   <= cwpDec;
                depth <= depth - 1'b1;
            end
            if (fillDone) begin
                cwp   <= cwpDec;
                saved <= saved - 1'b1;
            end
            if (doFlush) begin
                cwp   <= '0;
                depth <= DW'(1);
                saved <= '0;
            end
        end
    end

endmodule

// File: tb/tb_reg_window_file.sv
// Bench for reg_window_file: directed scenarios plus random command/write traffic
// against a transaction-level window model; the bench plays the off-chip window stack.
module tb_reg_window_file;
    localparam int WIDTH = 8, NWIN = 4, LOCAL = 4, MAX_SAVED = 15;
    localparam int AW = $clog2(LOCAL), SW = $clog2(MAX_SAVED + 1);
    localparam int CW = $clog2(NWIN), DW = $clog2(NWIN + 1);

    typedef logic [LOCAL-1:0][WIDTH-1:0] frame_t;

    logic             clk = 1'b0;
    logic             rst, regWrite, ldWnd, spillAck, fillValid;
    logic [AW-1:0]    wrAddr, rdAddr1, rdAddr2;
    logic [WIDTH-1:0] wrData, fillData;
    logic [1:0]       wndCtrl;
    logic [WIDTH-1:0] rdData1, rdData2, spillData;
    logic             stall, ovf, unf, spillReq, fillReq;
    logic [CW-1:0]    cwp;
    logic [DW-1:0]    depth;
    logic [SW-1:0]    saved;

    always #5 clk = ~clk;

    reg_window_file #(.WIDTH(WIDTH), .NWIN(NWIN), .LOCAL(LOCAL), .MAX_SAVED(MAX_SAVED)) dut (
        .clk(clk), .rst(rst), .regWrite(regWrite), .wrAddr(wrAddr),
        .rdAddr1(rdAddr1), .rdAddr2(rdAddr2), .wrData(wrData),
        .rdData1(rdData1), .rdData2(rdData2), .ldWnd(ldWnd), .wndCtrl(wndCtrl),
        .stall(stall), .cwp(cwp), .depth(depth), .saved(saved), .ovf(ovf), .unf(unf),
        .spillReq(spillReq), .spillData(spillData), .spillAck(spillAck),
        .fillReq(fillReq), .fillData(fillData), .fillValid(fillValid)
    );

    int     nChecks = 0, nBad = 0;
    frame_t mWin [NWIN];
    frame_t mMem [$];
    int     mCwp, mDepth, mSaved;
    int     holdMax = 0, forceHold = 0, fillAbortAt = -1;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic modelReset();
        for (int w = 0; w < NWIN; w++) mWin[w] = '0;
        mMem.delete();
        mCwp = 0; mDepth = 1; mSaved = 0;
    endtask

    task automatic checkIdle(input string tag);
        checkVal({tag, "/cwp"},   32'(cwp),   32'(mCwp));
        checkVal({tag, "/depth"}, 32'(depth), 32'(mDepth));
        checkVal({tag, "/saved"}, 32'(saved), 32'(mSaved));
        checkVal({tag, "/stall"}, 32'(stall), 32'd0);
        checkVal({tag, "/reqs"},  32'({spillReq, fillReq}), 32'd0);
    endtask

    task automatic checkRegs(input string tag);
        for (int i = 0; i < LOCAL; i++) begin
            rdAddr1 = AW'(i);
            rdAddr2 = AW'(LOCAL - 1 - i);
            #1;
            checkVal($sformatf("%s/rd1[%0d]", tag, i), 32'(rdData1), 32'(mWin[mCwp][i]));
            checkVal($sformatf("%s/rd2[%0d]", tag, LOCAL - 1 - i), 32'(rdData2),
                     32'(mWin[mCwp][LOCAL - 1 - i]));
        end
    endtask

    task automatic checkResetOuts(input string tag);
        checkIdle(tag);
        checkVal({tag, "/ovfunf"},    32'({ovf, unf}), 32'd0);
        checkVal({tag, "/spillData"}, 32'(spillData), 32'd0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        #1;
        modelReset();
        checkResetOuts("reset");
        checkRegs("resetRegs");
        tick();
        rst = 1'b0;
    endtask

    task automatic doWrite(input int a, input logic [WIDTH-1:0] d);
        regWrite = 1'b1; wrAddr = AW'(a); wrData = d;
        tick();
        regWrite = 1'b0;
        mWin[mCwp][a] = d;
    endtask

    function automatic int holdFor(input int b);
        if (b == 0 && forceHold > 0) return forceHold;
        if (holdMax > 0) return int'($urandom_range(holdMax, 0));
        return 0;
    endfunction

    task automatic runSpill();
        int     old, h;
        frame_t f;
        old = (mCwp + 1) % NWIN;
        f   = mWin[old];
        for (int b = 0; b < LOCAL; b++) begin
            h = holdFor(b);
            for (int k = 0; k < h; k++) begin
                spillAck  = 1'b0;
                regWrite  = 1'($urandom);
                wrAddr    = AW'($urandom);
                wrData    = WIDTH'($urandom);
                fillValid = 1'($urandom);
                #1;
                checkVal("spillHold/stall", 32'(stall), 32'd1);
                checkVal("spillHold/reqs",  32'({spillReq, fillReq}), 32'd2);
                checkVal($sformatf("spillHold/data[%0d]", b), 32'(spillData), 32'(f[b]));
                tick();
            end
            regWrite = 1'b0; fillValid = 1'b0; spillAck = 1'b1;
            #1;
            checkVal($sformatf("spill/data[%0d]", b), 32'(spillData), 32'(f[b]));
            checkVal("spill/stall", 32'(stall), 32'd1);
            tick();
            spillAck = 1'b0;
        end
        mMem.push_back(f);
        mSaved++;
        mCwp = old;
        mWin[old] = '0;
    endtask

    task automatic runFill();
        int     tgt, h;
        frame_t f;
        tgt = (mCwp + NWIN - 1) % NWIN;
        f   = mMem.pop_back();
        for (int b = 0; b < LOCAL; b++) begin
            if (b == fillAbortAt) begin
                fillValid = 1'b0;
                rst = 1'b1;
                #1;
                modelReset();
                checkResetOuts("fillAbort");
                tick();
                rst = 1'b0;
                checkResetOuts("fillAbortNext");
                checkRegs("fillAbortRegs");
                return;
            end
            h = holdFor(b);
            for (int k = 0; k < h; k++) begin
                fillValid = 1'b0;
                spillAck  = 1'($urandom);
                fillData  = WIDTH'($urandom);
                #1;
                checkVal("fillHold/stall", 32'(stall), 32'd1);
                checkVal("fillHold/reqs",  32'({spillReq, fillReq}), 32'd1);
                tick();
            end
            spillAck = 1'b0; fillValid = 1'b1; fillData = f[b];
            #1;
            checkVal("fill/stall", 32'(stall), 32'd1);
            tick();
            fillValid = 1'b0;
        end
        mWin[tgt] = f;
        mCwp = tgt;
        mSaved--;
    endtask

    task automatic doCmd(input logic [1:0] ctrl, input bit withWr, input int a,
                         input logic [WIDTH-1:0] d);
        bit expOvf, expUnf;
        expOvf = (ctrl == 2'b01) && (mDepth == NWIN) && (mSaved == MAX_SAVED);
        expUnf = (ctrl == 2'b10) && (mDepth == 1) && (mSaved == 0);
        if (withWr) mWin[mCwp][a] = d;
        ldWnd = 1'b1; wndCtrl = ctrl; regWrite = withWr; wrAddr = AW'(a); wrData = d;
        tick();
        ldWnd = 1'b0; wndCtrl = 2'b00; regWrite = 1'b0;
        checkVal("ovf", 32'(ovf), 32'(expOvf));
        checkVal("unf", 32'(unf), 32'(expUnf));
        if (expOvf || expUnf) begin
            checkVal("errNoStall", 32'(stall), 32'd0);
            tick();
            checkVal("errPulseEnd", 32'({ovf, unf}), 32'd0);
        end
        case (ctrl)
            2'b01: begin
                if (mDepth < NWIN) begin
                    mCwp = (mCwp + 1) % NWIN;
                    mDepth++;
                    mWin[mCwp] = '0;
                end else if (mSaved < MAX_SAVED) begin
                    runSpill();
                end
            end
            2'b10: begin
                if (mDepth > 1) begin
                    mCwp = (mCwp + NWIN - 1) % NWIN;
                    mDepth--;
                end else if (mSaved > 0) begin
                    runFill();
                end
            end
            2'b11: begin
                mCwp = 0; mDepth = 1; mSaved = 0;
                mMem.delete();
            end
            default: ;
        endcase
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, a;
        logic [WIDTH-1:0] d;
        rst = 1'b1; regWrite = 1'b0; ldWnd = 1'b0; wndCtrl = 2'b00;
        wrAddr = '0; rdAddr1 = '0; rdAddr2 = '0; wrData = '0;
        spillAck = 1'b0; fillValid = 1'b0; fillData = '0;
        #1;
        doReset();

        // basic write then read next cycle
        doWrite(1, 8'h5A);
        rdAddr1 = AW'(1);
        #1;
        checkVal("r1readback", 32'(rdData1), 32'h5A);
        checkIdle("afterWrite");

        // fill window 0, call to full, then spill it
        for (int i = 0; i < LOCAL; i++) doWrite(i, WIDTH'(8'hA0 + i));
        repeat (3) doCmd(2'b01, 1'b0, 0, '0);
        checkVal("threeCalls/cwp",   32'(cwp),   32'd3);
        checkVal("threeCalls/depth", 32'(depth), 32'd4);
        checkIdle("threeCalls");
        doCmd(2'b01, 1'b0, 0, '0);
        checkVal("spillDone/cwp",   32'(cwp),   32'd0);
        checkVal("spillDone/saved", 32'(saved), 32'd1);
        checkIdle("spillDone");

        // unwind and fill with fixed data
        repeat (3) doCmd(2'b10, 1'b0, 0, '0);
        checkVal("threeRets/cwp",   32'(cwp),   32'd1);
        checkVal("threeRets/depth", 32'(depth), 32'd1);
        mMem[mMem.size() - 1] = {8'h44, 8'h33, 8'h22, 8'h11};
        doCmd(2'b10, 1'b0, 0, '0);
        checkVal("fillDone/cwp",   32'(cwp),   32'd0);
        checkVal("fillDone/saved", 32'(saved), 32'd0);
        checkIdle("fillDone");
        checkRegs("fillDoneRegs");

        // underflow and overflow
        doReset();
        doCmd(2'b10, 1'b0, 0, '0);
        checkIdle("afterUnf");
        repeat (3 + MAX_SAVED) doCmd(2'b01, 1'b0, 0, '0);
        checkVal("fullSaved", 32'(saved), 32'(MAX_SAVED));
        doCmd(2'b01, 1'b0, 0, '0);
        checkIdle("afterOvf");

        // long ack stall with writes attempted, then look at the untouched window
        doCmd(2'b11, 1'b1, 2, 8'hC3);
        checkIdle("afterFlush");
        checkRegs("afterFlushRegs");
        doWrite(0, 8'h77);
        repeat (3) doCmd(2'b01, 1'b0, 0, '0);
        doWrite(3, 8'h9E);
        forceHold = 5;
        doCmd(2'b01, 1'b0, 0, '0);
        forceHold = 0;
        checkIdle("afterHeldSpill");
        doCmd(2'b10, 1'b0, 0, '0);
        checkRegs("heldSpillRegs");

        // reset in the middle of a fill
        doReset();
        for (int i = 0; i < LOCAL; i++) doWrite(i, WIDTH'($urandom));
        repeat (4) doCmd(2'b01, 1'b0, 0, '0);
        repeat (3) doCmd(2'b10, 1'b0, 0, '0);
        fillAbortAt = 2;
        doCmd(2'b10, 1'b0, 0, '0);
        fillAbortAt = -1;

        // random traffic
        doReset();
        holdMax = 2;
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(99, 0));
            a = int'($urandom_range(LOCAL - 1, 0));
            d = WIDTH'($urandom);
            if (r < 30)      doWrite(a, d);
            else if (r < 62) doCmd(2'b01, 1'($urandom), a, d);
            else if (r < 90) doCmd(2'b10, 1'($urandom), a, d);
            else if (r < 93) doCmd(2'b11, 1'($urandom), a, d);
            else             doCmd(2'b00, 1'($urandom), a, d);
            checkIdle("rnd");
            if (n % 4 == 0) checkRegs("rndRegs");
        end

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end
endmodule
